uart_rx: RTL and testbench

- Serial receiver for the 8N1 UART link, 16x oversampled from a baud-rate tick enable.
- Converts the serial line into bytes for the RX FIFO side of the design.
- Detects a start bit and samples each bit at mid-point using a 3-sample majority vote.
- Checks the stop bit, presents the byte through a valid/ready handshake, and flags framing and overrun errors.

---
 rtl/uart_rx.sv | 206 ++++++++++++++++++++
 tb/tb_uart_rx.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x oversampled from a baud tick, 3-sample majority vote
// at mid-bit, valid/ready byte output with framing and sticky overrun flags.
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 iRX_BAUD_tick,
    input  logic                 iRX_DATA,
    input  logic                 iRX_READY,
    output logic [DATA_BITS-1:0] oRX_BYTE,
    output logic                 oRX_VALID,
    output logic                 oRX_FRAME_ERR,
    output logic                 oRX_OVERRUN,
    output logic                 oRX_BUSY
);

    localparam int MID  = OVERSAMPLE / 2;
    localparam int TC_W = $clog2(OVERSAMPLE);
    localparam int BC_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TC_W-1:0] TC_LO   = TC_W'(MID - 1);
    localparam logic [TC_W-1:0] TC_MID  = TC_W'(MID);
    localparam logic [TC_W-1:0] TC_HI   = TC_W'(MID + 1);
    localparam logic [TC_W-1:0] TC_LAST = TC_W'(OVERSAMPLE - 1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    state_t               state_r;
    logic [TC_W-1:0]      tc_r;
    logic [BC_W-1:0]      bit_cnt_r;
    logic [DATA_BITS-1:0] shift_r;
    logic [1:0]           smp_r;
    logic                 rx_meta_r;
    logic                 rx_sync_r;
    logic                 wait_high_r;
    logic [DATA_BITS-1:0] byte_r;
    logic                 valid_r;
    logic                 ferr_r;
    logic                 overrun_r;
    logic                 busy_r;

    logic                 vote_s;
    logic                 accept_s;
    logic                 frame_done_s;

    // Two-flop synchronizer for the asynchronous serial line, idle-high preset
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= iRX_DATA;
            rx_sync_r <= rx_meta_r;
        end
    end

    // Third vote sample is the live synchronized value at tc = MID+1
    assign vote_s       = majority3(smp_r[0], smp_r[1], rx_sync_r);
    assign accept_s     = valid_r & iRX_READY;
    assign frame_done_s = iRX_BAUD_tick & (state_r == ST_STOP) & (tc_r == TC_HI);

    // Receive FSM (tick-gated) plus the per-clk output handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            tc_r        <= '0;
            bit_cnt_r   <= '0;
            shift_r     <= '0;
            smp_r       <= 2'b00;
            wait_high_r <= 1'b0;
            byte_r      <= '0;
            valid_r     <= 1'b0;
            ferr_r      <= 1'b0;
            overrun_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            if (accept_s) begin
                valid_r <= 1'b0;
            end
            // A new frame load overrides a same-clk accept
            if (frame_done_s) begin
                if (!valid_r || iRX_READY) begin
                    byte_r  <= shift_r;
                    ferr_r  <= ~vote_s;
                    valid_r <= 1'b1;
                end else begin
                    overrun_r <= 1'b1;
                end
            end

            if (iRX_BAUD_tick) begin
                if (tc_r == TC_LO) begin
                    smp_r[0] <= rx_sync_r;
                end
                if (tc_r == TC_MID) begin
                    smp_r[1] <= rx_sync_r;
                end

                case (state_r)
                    ST_IDLE: begin
                        tc_r      <= '0;
                        bit_cnt_r <= '0;
                        // After a low stop bit the line must go high before a new start
                        if (rx_sync_r) begin
                            wait_high_r <= 1'b0;
                        end else if (!wait_high_r) begin
                            state_r <= ST_START;
                            busy_r  <= 1'b1;
                        end
                    end
                    ST_START: begin
                        if ((tc_r == TC_HI) && vote_s) begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                            tc_r    <= '0;
                        end else if (tc_r == TC_LAST) begin
                            state_r   <= ST_DATA;
                            tc_r      <= '0;
                            bit_cnt_r <= '0;
                        end else begin
                            tc_r <= tc_r + 1'b1;
                        end
                    end
                    ST_DATA: begin
                        if (tc_r == TC_HI) begin
                            shift_r <= {vote_s, shift_r[DATA_BITS-1:1]};
                        end
                        if (tc_r == TC_LAST) begin
                            tc_r <= '0;
                            if (bit_cnt_r == BC_LAST) begin
                                state_r <= ST_STOP;
                            end else begin
                                bit_cnt_r <= bit_cnt_r + 1'b1;
                            end
                        end else begin
                            tc_r <= tc_r + 1'b1;
                        end
                    end
                    ST_STOP: begin
                        if (tc_r == TC_HI) begin
                            state_r     <= ST_IDLE;
                            busy_r      <= 1'b0;
                            tc_r        <= '0;
                            wait_high_r <= ~vote_s;
                        end else begin
                            tc_r <= tc_r + 1'b1;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        tc_r    <= '0;
                    end
                endcase
            end
        end
    end

    assign oRX_BYTE      = byte_r;
    assign oRX_VALID     = valid_r;
    assign oRX_FRAME_ERR = ferr_r;
    assign oRX_OVERRUN   = overrun_r;
    assign oRX_BUSY      = busy_r;

    uart_rx_checker #(.DATA_BITS(DATA_BITS)) u_checker (
        .clk       (clk),
        .reset     (reset),
        .rx_ready  (iRX_READY),
        .rx_byte   (oRX_BYTE),
        .rx_valid  (oRX_VALID),
        .rx_overrun(oRX_OVERRUN)
    );

endmodule

// Handshake invariants: a held byte stays put and overrun is sticky.
module uart_rx_checker #(
    parameter int DATA_BITS = 8
) (
    input logic                 clk,
    input logic                 reset,
    input logic                 rx_ready,
    input logic [DATA_BITS-1:0] rx_byte,
    input logic                 rx_valid,
    input logic                 rx_overrun
);

    a_hold_stable: assert property (@(posedge clk) disable iff (reset)
        (rx_valid && !rx_ready) |=> (rx_valid && $stable(rx_byte)));

    a_overrun_sticky: assert property (@(posedge clk) disable iff (reset)
        rx_overrun |=> rx_overrun);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected {frame_err, byte},
// a monitor pops and compares on every accepted byte.
module tb_uart_rx;

    logic       clk;
    logic       reset;
    logic       iRX_BAUD_tick;
    logic       iRX_DATA;
    logic       iRX_READY;
    logic [7:0] oRX_BYTE;
    logic       oRX_VALID;
    logic       oRX_FRAME_ERR;
    logic       oRX_OVERRUN;
    logic       oRX_BUSY;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int acc_cnt   = 0;
    logic [8:0] exp_q[$];

    uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .iRX_BAUD_tick(iRX_BAUD_tick),
        .iRX_DATA     (iRX_DATA),
        .iRX_READY    (iRX_READY),
        .oRX_BYTE     (oRX_BYTE),
        .oRX_VALID    (oRX_VALID),
        .oRX_FRAME_ERR(oRX_FRAME_ERR),
        .oRX_OVERRUN  (oRX_OVERRUN),
        .oRX_BUSY     (oRX_BUSY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Baud tick every 4 clks, updated on the falling edge
    initial begin
        logic [1:0] tdiv;
        tdiv = 2'd0;
        iRX_BAUD_tick = 1'b0;
        forever begin
            @(negedge clk);
            tdiv = tdiv + 2'd1;
            iRX_BAUD_tick = (tdiv == 2'd3);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            do @(posedge clk); while (!iRX_BAUD_tick);
        end
        #1;
    endtask

    task automatic line(input logic v, input int n);
        iRX_DATA = v;
        wait_ticks(n);
    endtask

    // Full 8N1 frame; optional 1-tick low spike at tick offset spike_off of data bit spike_bit
    task automatic send_frame(input logic [7:0] b, input logic stop_v,
                              input int spike_bit, input int spike_off);
        line(1'b0, 16);
        for (int i = 0; i < 8; i++) begin
            if (i == spike_bit) begin
                line(b[i], spike_off);
                line(1'b0, 1);
                line(b[i], 16 - spike_off - 1);
            end else begin
                line(b[i], 16);
            end
        end
        line(stop_v, 16);
    endtask

    // Monitor: compare each accepted byte against the scoreboard head
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (!reset && oRX_VALID && iRX_READY) begin
                acc_cnt++;
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_byte: got 0x%0h ferr %0d expected none",
                             oRX_BYTE, oRX_FRAME_ERR);
                end else begin
                    e = exp_q.pop_front();
                    check("rx_byte", int'(oRX_BYTE), int'(e[7:0]));
                    check("rx_frame_err", int'(oRX_FRAME_ERR), int'(e[8]));
                end
            end
        end
    end

    initial begin
        int acc0;
        int busy_ticks;
        reset = 1'b1;
        iRX_DATA = 1'b1;
        iRX_READY = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_valid", int'(oRX_VALID), 0);
        check("reset_busy", int'(oRX_BUSY), 0);
        check("reset_overrun", int'(oRX_OVERRUN), 0);
        check("reset_byte", int'(oRX_BYTE), 0);
        check("reset_frame_err", int'(oRX_FRAME_ERR), 0);
        line(1'b1, 8);

        // Reset mid-frame, then a clean 0x3C
        line(1'b0, 16);
        line(1'b1, 16);
        line(1'b0, 16);
        line(1'b1, 16);
        check("midframe_busy", int'(oRX_BUSY), 1);
        reset = 1'b1;
        iRX_DATA = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midreset_valid", int'(oRX_VALID), 0);
        check("midreset_busy", int'(oRX_BUSY), 0);
        line(1'b1, 32);
        exp_q.push_back({1'b0, 8'h3C});
        send_frame(8'h3C, 1'b1, -1, 0);
        line(1'b1, 32);

        // Basic frame 0xA5
        acc0 = acc_cnt;
        exp_q.push_back({1'b0, 8'hA5});
        send_frame(8'hA5, 1'b1, -1, 0);
        line(1'b1, 32);
        check("basic_count", acc_cnt - acc0, 1);

        // Glitch rejection
        acc0 = acc_cnt;
        busy_ticks = 0;
        iRX_DATA = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i == 4) iRX_DATA = 1'b1;
            wait_ticks(1);
            if (oRX_BUSY) busy_ticks++;
        end
        total_cnt++;
        if (busy_ticks >= 1 && busy_ticks <= 10) pass_cnt++;
        else $display("FAIL glitch_busy_ticks: got %0d expected 1..10", busy_ticks);
        check("glitch_busy_end", int'(oRX_BUSY), 0);
        check("glitch_count", acc_cnt - acc0, 0);

        // Mid-bit noise spike inside data bit 3 of 0xFF
        exp_q.push_back({1'b0, 8'hFF});
        send_frame(8'hFF, 1'b1, 3, 9);
        line(1'b1, 32);

        // Framing error on 0x55
        exp_q.push_back({1'b1, 8'h55});
        send_frame(8'h55, 1'b0, -1, 0);
        line(1'b1, 32);

        // Break: 20 bit periods low yields a single 0x00 framing-error byte
        acc0 = acc_cnt;
        exp_q.push_back({1'b1, 8'h00});
        line(1'b0, 320);
        check("break_count", acc_cnt - acc0, 1);
        check("break_busy", int'(oRX_BUSY), 0);
        line(1'b1, 32);
        check("break_after_high_count", acc_cnt - acc0, 1);

        // Overrun with back-to-back frames
        iRX_READY = 1'b0;
        exp_q.push_back({1'b0, 8'h11});
        send_frame(8'h11, 1'b1, -1, 0);
        check("first_valid", int'(oRX_VALID), 1);
        check("first_no_overrun", int'(oRX_OVERRUN), 0);
        send_frame(8'h22, 1'b1, -1, 0);
        line(1'b1, 8);
        check("ovr_valid", int'(oRX_VALID), 1);
        check("ovr_byte_held", int'(oRX_BYTE), 8'h11);
        check("ovr_flag", int'(oRX_OVERRUN), 1);
        iRX_READY = 1'b1;
        @(posedge clk);
        #1;
        iRX_READY = 1'b0;
        check("ovr_valid_dropped", int'(oRX_VALID), 0);
        iRX_READY = 1'b1;
        exp_q.push_back({1'b0, 8'h33});
        send_frame(8'h33, 1'b1, -1, 0);
        line(1'b1, 32);
        check("ovr_sticky", int'(oRX_OVERRUN), 1);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
